// File: rtl/id_exe_pkg.sv
// Shared widths, bundle layout and state encoding for the ID->EXE stage.
package id_exe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned EXE_W   = 3;
  localparam int unsigned MEM_W   = 3;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned CNT_W   = 16;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [ALU_W-1:0]   alu;
    logic [RADDR_W-1:0] wb_addr;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [EXE_W-1:0]   exe;
    logic [MEM_W-1:0]   mem;
    logic [WB_W-1:0]    wb;
  } id_exe_bundle_t;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } skid_state_t;

  localparam logic [EXE_W+MEM_W+WB_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/id_exe_skid_stage_buf.sv
// Generic 2-entry skid buffer: main register drives the outputs, skid register
// absorbs one extra beat so in_ready depends only on registered state.
module pipe_skid_buf
  import id_exe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         in_fire, out_fire;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_ready  = rst & (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d        = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/id_exe_skid_stage.sv
// ID->EXE pipeline stage: packs the decoded bundle through a skid buffer,
// forces bubble control to NOP, and counts back-pressure cycles.
module id_exe_skid_stage
  import id_exe_pkg::*;
#(
  parameter int unsigned XLEN    = id_exe_pkg::XLEN,
  parameter int unsigned RADDR_W = id_exe_pkg::RADDR_W,
  parameter int unsigned ALU_W   = id_exe_pkg::ALU_W,
  parameter int unsigned EXE_W   = id_exe_pkg::EXE_W,
  parameter int unsigned MEM_W   = id_exe_pkg::MEM_W,
  parameter int unsigned WB_W    = id_exe_pkg::WB_W,
  parameter int unsigned CNT_W   = id_exe_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    rs1_data_in,
  input  logic [XLEN-1:0]    rs2_data_in,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [ALU_W-1:0]   alu_in,
  input  logic [RADDR_W-1:0] wb_addr_in,
  input  logic [RADDR_W-1:0] rs1_addr_in,
  input  logic [RADDR_W-1:0] rs2_addr_in,
  input  logic [EXE_W-1:0]   exe_in,
  input  logic [MEM_W-1:0]   mem_in,
  input  logic [WB_W-1:0]    wb_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,
  output logic [XLEN-1:0]    imm,
  output logic [ALU_W-1:0]   alu,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [RADDR_W-1:0] rs1_addr,
  output logic [RADDR_W-1:0] rs2_addr,
  output logic [EXE_W-1:0]   exe,
  output logic [MEM_W-1:0]   mem,
  output logic [WB_W-1:0]    wb,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned CTRL_W = EXE_W + MEM_W + WB_W;

  // Local layout follows the module parameters so width overrides stay consistent.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [ALU_W-1:0]   alu;
    logic [RADDR_W-1:0] wb_addr;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [EXE_W-1:0]   exe;
    logic [MEM_W-1:0]   mem;
    logic [WB_W-1:0]    wb;
  } bundle_t;

  bundle_t in_b, main_b;

  assign in_b = {pc_in, rs1_data_in, rs2_data_in, imm_in, alu_in,
                 wb_addr_in, rs1_addr_in, rs2_addr_in, exe_in, mem_in, wb_in};

  pipe_skid_buf #(
    .W($bits(bundle_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (main_b)
  );

  assign pc       = main_b.pc;
  assign rs1_data = main_b.rs1_data;
  assign rs2_data = main_b.rs2_data;
  assign imm      = main_b.imm;
  assign alu      = main_b.alu;
  assign wb_addr  = main_b.wb_addr;
  assign rs1_addr = main_b.rs1_addr;
  assign rs2_addr = main_b.rs2_addr;

  // Drained/flushed entries keep stale data but must present NOP control.
  assign {exe, mem, wb} = out_valid ? {main_b.exe, main_b.mem, main_b.wb}
                                    : CTRL_W'(NOP_CTRL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
